sequenciador_manobra: RTL and testbench
=======================================

# sequenciador_manobra

Clocked motion sequencer directly downstream of the robot's obstacle-decision logic. It consumes the power-enable and the Erro/Ré/Girar decision flags and turns them into timed, committed H-bridge commands for the left and right motors. It also reports its current state for display. A reverse request becomes a fixed-length reverse followed by a fixed-length turn, so the robot cannot oscillate when sensor inputs chatter.

## Interface
- T_RE, default 8, cycles spent in RE per maneuver (≥1)
- T_GIRAR, default 6, cycles spent in GIRAR per maneuver (≥1)
- T_PAUSA, default 2, motors-off cycles before each direction reversal; used only with the macro (≥1)
- Clock  input  1  single clock; all state changes on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- Ligado  input  1  robot powered and battery OK
- Saida_Erro  input  1  sensor-combination error flag
- Saida_Re  input  1  reverse request
- Saida_Girar  input  1  turn request
- Motor_Esq_Frente / Motor_Esq_Tras  output  1 each  left H-bridge legs
- Motor_Dir_Frente / Motor_Dir_Tras  output  1 each  right H-bridge legs
- Estado  output  3  encoded current state
- Ocupado  output  1  high while a timed maneuver (RE, GIRAR, PAUSA) is in progress

## Operation
- States and Estado codes:
  - DESLIGADO=0: all motors off.
  - FRENTE=1: both motors forward.
  - RE=2: both motors reverse.
  - GIRAR=3: left forward, right reverse (turns right).
  - ERRO=4: all motors off.
  - PAUSA=5: all motors off; exists only with the macro.
- Global priority, evaluated every cycle from any state: !Ligado → DESLIGADO; else Saida_Erro → ERRO.
- DESLIGADO → FRENTE when Ligado && !Saida_Erro.
- ERRO → FRENTE on the first cycle Saida_Erro is low (Ligado high).
- FRENTE: Saida_Re → RE (priority over Girar); else Saida_Girar → GIRAR; else stay.
- RE lasts exactly T_RE cycles, then goes to GIRAR. GIRAR lasts exactly T_GIRAR cycles, then goes to FRENTE.
- Maneuver commitment: Saida_Re and Saida_Girar are ignored while in RE, GIRAR or PAUSA. Only !Ligado or Saida_Erro abort a maneuver.
- Counter: loaded with T−1 on state entry, decrements each cycle, and the state exits on the cycle it reads 0. Counter is cleared on abort.
- Counter width is $clog2 of the largest of T_RE, T_GIRAR, T_PAUSA, plus 1. No wrap: the counter never decrements below 0.
- Motor legs of one side are never both 1. This is guaranteed by the state decode.

## Timing
- Reset values: state DESLIGADO, counter 0, all Motor_* 0, Estado 0, Ocupado 0.
- Outputs are a Moore decode of the state register. An input sampled at edge N is reflected in outputs after edge N, giving 1-cycle latency.
- Ligado falling mid-maneuver: DESLIGADO after the next edge, motors off, Ocupado 0.
- Saida_Erro and Saida_Re high together: Erro wins.
- Reset_n asserted mid-maneuver: immediate asynchronous return to reset values. No maneuver resumes after release.
- Inputs are assumed synchronous to Clock. Upstream logic is combinational from synchronized sensors.

## Configuration
- SEQUENCIADOR_PAUSA_EN defined:
  - FRENTE→RE and RE→GIRAR each pass through PAUSA for exactly T_PAUSA cycles, motors off, Ocupado 1.
  - PAUSA's successor is held in a 1-bit register.
  - GIRAR→FRENTE has no pause.
- SEQUENCIADOR_PAUSA_EN undefined:
  - PAUSA state, its register and T_PAUSA logic are absent.
  - Transitions are direct.
  - Estado never reads 5.

## Structure
- Package manobra_pkg holds:
  - the state enum with the codes above;
  - a 4-bit motor command type;
  - constants CMD_PARADO, CMD_FRENTE, CMD_RE, CMD_GIRAR_DIR.
- One sub-module, contador_manobra: loadable down-counter with load, value, zero flag and clear.
- Top level holds the FSM and the output decode.

## Test plan
Bench parameters: T_RE=4, T_GIRAR=3, T_PAUSA=2.
- Reset, then Ligado=1 with no flags → Estado 0 then 1 one cycle later; Motor_Esq_Frente=Motor_Dir_Frente=1, others 0.
- Saida_Re pulsed for 1 cycle in FRENTE → RE for exactly 4 cycles, GIRAR for exactly 3, then FRENTE. Ocupado high for exactly 7 cycles.
- Saida_Re and Saida_Girar toggled every cycle during the maneuver → timing identical to the previous scenario.
- Saida_Erro raised on the 2nd RE cycle → ERRO next cycle, motors 0. Erro cleared → FRENTE next cycle.
- Ligado dropped in GIRAR → Estado 0, Ocupado 0. Reset_n pulsed low mid-RE → all outputs 0 asynchronously.
- SEQUENCIADOR_PAUSA_EN build, Saida_Re pulse → 2 PAUSA, 4 RE, 2 PAUSA, 3 GIRAR, then FRENTE. Ocupado high for 11 cycles.

Source files
------------

// File: rtl/manobra_pkg.sv
// manobra_pkg: state codes, motor command type and helpers for sequenciador_manobra.
// PAUSA exists only when SEQUENCIADOR_PAUSA_EN is defined.
package manobra_pkg;
  typedef enum logic [2:0] {
    DESLIGADO = 3'd0,
    FRENTE    = 3'd1,
    RE        = 3'd2,
    GIRAR     = 3'd3,
    ERRO      = 3'd4
`ifdef SEQUENCIADOR_PAUSA_EN
    , PAUSA   = 3'd5
`endif
  } estado_t;
  // {esq_frente, esq_tras, dir_frente, dir_tras}
  typedef logic [3:0] cmd_t;
  localparam cmd_t CMD_PARADO    = 4'b0000;
  localparam cmd_t CMD_FRENTE    = 4'b1010;
  localparam cmd_t CMD_RE        = 4'b0101;
  localparam cmd_t CMD_GIRAR_DIR = 4'b1001;
  function automatic cmd_t cmd_de_estado(estado_t e);
    return e == FRENTE ? CMD_FRENTE : e == RE ? CMD_RE : e == GIRAR ? CMD_GIRAR_DIR : CMD_PARADO;
  endfunction
  function automatic int max3(int a, int b, int c);
    return (a > b ? a : b) > c ? (a > b ? a : b) : c;
  endfunction
endpackage

// File: rtl/contador_manobra.sv
// contador_manobra: loadable down-counter that saturates at zero, with clear and zero flag.
module contador_manobra #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_valor,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_load) r_cnt <= i_valor;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/sequenciador_manobra.sv
// sequenciador_manobra: commits reverse/turn requests into timed H-bridge maneuvers.
// Define SEQUENCIADOR_PAUSA_EN to insert motors-off PAUSA before each direction reversal.
module sequenciador_manobra
  import manobra_pkg::*;
#(
  parameter int T_RE    = 8,
  parameter int T_GIRAR = 6,
  parameter int T_PAUSA = 2
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Ligado,
  input  logic       Saida_Erro,
  input  logic       Saida_Re,
  input  logic       Saida_Girar,
  output logic       Motor_Esq_Frente,
  output logic       Motor_Esq_Tras,
  output logic       Motor_Dir_Frente,
  output logic       Motor_Dir_Tras,
  output logic [2:0] Estado,
  output logic       Ocupado
);
  localparam int W = $clog2(max3(T_RE, T_GIRAR, T_PAUSA)) + 1;
  localparam logic [W-1:0] C_RE    = W'(T_RE - 1);
  localparam logic [W-1:0] C_GIRAR = W'(T_GIRAR - 1);
`ifdef SEQUENCIADOR_PAUSA_EN
  localparam logic [W-1:0] C_PAUSA = W'(T_PAUSA - 1);
  logic r_pos_girar, w_pos_girar;
`endif
  estado_t      r_estado, w_prox;
  logic         w_load, w_clear, w_zero;
  logic [W-1:0] w_carga;
  contador_manobra #(.W(W)) u_contador (
    .clk     (Clock),
    .rst_n   (Reset_n),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_valor (w_carga),
    .o_zero  (w_zero)
  );
  always_comb begin
    w_prox  = r_estado;
    w_load  = 1'b0;
    w_clear = 1'b0;
    w_carga = '0;
`ifdef SEQUENCIADOR_PAUSA_EN
    w_pos_girar = r_pos_girar;
`endif
    if (!Ligado || Saida_Erro) begin
      w_prox  = Ligado ? ERRO : DESLIGADO;
      w_clear = 1'b1;
    end else
      case (r_estado)
        FRENTE:
          if (Saida_Re) begin
`ifdef SEQUENCIADOR_PAUSA_EN
            w_prox      = PAUSA;
            w_pos_girar = 1'b0;
            w_carga     = C_PAUSA;
`else
            w_prox  = RE;
            w_carga = C_RE;
`endif
            w_load = 1'b1;
          end else if (Saida_Girar) begin
            w_prox  = GIRAR;
            w_load  = 1'b1;
            w_carga = C_GIRAR;
          end
        RE:
          if (w_zero) begin
`ifdef SEQUENCIADOR_PAUSA_EN
            w_prox      = PAUSA;
            w_pos_girar = 1'b1;
            w_carga     = C_PAUSA;
`else
            w_prox  = GIRAR;
            w_carga = C_GIRAR;
`endif
            w_load = 1'b1;
          end
        GIRAR: w_prox = w_zero ? FRENTE : GIRAR;
`ifdef SEQUENCIADOR_PAUSA_EN
        PAUSA:
          if (w_zero) begin
            w_prox  = r_pos_girar ? GIRAR : RE;
            w_load  = 1'b1;
            w_carga = r_pos_girar ? C_GIRAR : C_RE;
          end
`endif
        default: w_prox = FRENTE;
      endcase
  end
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) r_estado <= DESLIGADO;
    else r_estado <= w_prox;
`ifdef SEQUENCIADOR_PAUSA_EN
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) r_pos_girar <= 1'b0;
    else r_pos_girar <= w_pos_girar;
  assign Ocupado = r_estado inside {RE, GIRAR, PAUSA};
`else
  assign Ocupado = r_estado inside {RE, GIRAR};
`endif
  assign {Motor_Esq_Frente, Motor_Esq_Tras, Motor_Dir_Frente, Motor_Dir_Tras} = cmd_de_estado(r_estado);
  assign Estado = r_estado;
endmodule

// File: tb/tb_sequenciador_manobra.sv
// tb_sequenciador_manobra: directed and random stimulus against a maneuver-plan reference model.
module tb_sequenciador_manobra;
  localparam int T_RE    = 4;
  localparam int T_GIRAR = 3;
  localparam int T_PAUSA = 2;
`ifdef SEQUENCIADOR_PAUSA_EN
  localparam int EXP_OCUP = T_PAUSA + T_RE + T_PAUSA + T_GIRAR;
`else
  localparam int EXP_OCUP = T_RE + T_GIRAR;
`endif
  logic       Clock = 1'b0, Reset_n = 1'b1;
  logic       Ligado = 1'b0, Saida_Erro = 1'b0, Saida_Re = 1'b0, Saida_Girar = 1'b0;
  logic       mef, met, mdf, mdt, Ocupado;
  logic [2:0] Estado;
  int n_tests = 0, n_fail = 0, n_ocup = 0;
  int st = 0;
  int plan[$];
  always #5 Clock = ~Clock;
  sequenciador_manobra #(.T_RE(T_RE), .T_GIRAR(T_GIRAR), .T_PAUSA(T_PAUSA)) dut (
    .Clock            (Clock),
    .Reset_n          (Reset_n),
    .Ligado           (Ligado),
    .Saida_Erro       (Saida_Erro),
    .Saida_Re         (Saida_Re),
    .Saida_Girar      (Saida_Girar),
    .Motor_Esq_Frente (mef),
    .Motor_Esq_Tras   (met),
    .Motor_Dir_Frente (mdf),
    .Motor_Dir_Tras   (mdt),
    .Estado           (Estado),
    .Ocupado          (Ocupado)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [3:0] motores(int s);
    return s == 1 ? 4'b1010 : s == 2 ? 4'b0101 : s == 3 ? 4'b1001 : 4'b0000;
  endfunction
  task automatic push_n(int s, int n);
    repeat (n) plan.push_back(s);
  endtask
  // A maneuver is a precomputed list of future states; flags are ignored while it drains.
  task automatic modelo(logic lig, logic erro, logic re, logic gir);
    if (!lig) begin
      st = 0;
      plan.delete();
    end else if (erro) begin
      st = 4;
      plan.delete();
    end else if (plan.size() > 0) st = plan.pop_front();
    else if (st != 1) st = 1;
    else if (re || gir) begin
      if (re) begin
`ifdef SEQUENCIADOR_PAUSA_EN
        push_n(5, T_PAUSA);
`endif
        push_n(2, T_RE);
`ifdef SEQUENCIADOR_PAUSA_EN
        push_n(5, T_PAUSA);
`endif
      end
      push_n(3, T_GIRAR);
      push_n(1, 1);
      st = plan.pop_front();
    end
  endtask
  task automatic verifica();
    check("estado", 32'(Estado), 32'(st));
    check("motores", 32'({mef, met, mdf, mdt}), 32'(motores(st)));
    check("ocupado", 32'(Ocupado), 32'(st == 2 || st == 3 || st == 5));
    check("pernas", 32'((mef & met) | (mdf & mdt)), 32'd0);
  endtask
  task automatic step(logic lig, logic erro, logic re, logic gir);
    Ligado = lig;
    Saida_Erro = erro;
    Saida_Re = re;
    Saida_Girar = gir;
    @(posedge Clock);
    modelo(lig, erro, re, gir);
    @(negedge Clock);
    verifica();
    if (Ocupado) n_ocup++;
  endtask
  task automatic resetar();
    #2 Reset_n = 1'b0;
    #1 st = 0;
    plan.delete();
    verifica();
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask
  task automatic ate_estado(int alvo, string tag);
    for (int i = 0; i < 20 && st != alvo; i++) step(1, 0, 0, 0);
    check(tag, 32'(Estado), 32'(alvo));
  endtask
  initial begin
    #1 Reset_n = 1'b0;
    #1 verifica();
    @(negedge Clock);
    Reset_n = 1'b1;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("liga_frente", 32'(Estado), 32'd1);
    step(1, 0, 0, 0);
    n_ocup = 0;
    step(1, 0, 1, 0);
    repeat (EXP_OCUP + 3) step(1, 0, 0, 0);
    check("ocup_len_pulso", 32'(n_ocup), 32'(EXP_OCUP));
    check("volta_frente", 32'(Estado), 32'd1);
    n_ocup = 0;
    step(1, 0, 1, 0);
    for (int i = 0; i < EXP_OCUP - 1; i++) step(1, 0, i[0], ~i[0]);
    repeat (3) step(1, 0, 0, 0);
    check("ocup_len_chatter", 32'(n_ocup), 32'(EXP_OCUP));
    step(1, 0, 1, 0);
    ate_estado(2, "alcanca_re");
    step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    check("erro_aborta", 32'(Estado), 32'd4);
    step(1, 0, 0, 0);
    check("erro_frente", 32'(Estado), 32'd1);
    step(1, 0, 1, 0);
    ate_estado(3, "alcanca_girar");
    step(0, 0, 0, 0);
    check("desliga_girar", 32'(Ocupado), 32'd0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    ate_estado(2, "alcanca_re2");
    step(1, 0, 0, 0);
    resetar();
    check("reset_assinc", 32'({Estado, mef, met, mdf, mdt, Ocupado}), 32'd0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) resetar();
      step($urandom_range(0, 19) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
